serial_paralelo: RTL and testbench

Single-lane receive deserializer for the PHY layer: the direct downstream counterpart of the transmit-side parallel-to-serial stage. It consumes one serial lane, MSB first, at clk_32f. It locates byte boundaries by hunting for the COM idle symbol and requires COM_COUNT consecutive aligned COMs before declaring the lane active. Once active, it emits 8-bit bytes with a one-cycle strobe every 8 clocks, plus a valid flag that is low for COM (idle) bytes. Two instances per PHY_RX feed the 8b-to-32b converters.

---
 rtl/serial_paralelo.sv | 116 +++++++++++
 tb/tb_serial_paralelo.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/serial_paralelo.sv
// rtl/serial_paralelo.sv - single-lane MSB-first deserializer with COM-based byte alignment
// Hunts for COM, confirms COM_COUNT aligned COMs, then strobes out one byte every 8 clocks.
module serial_paralelo #(
    parameter logic [7:0] COM       = 8'hBC,
    parameter int         COM_COUNT = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       byte_stb,
    output logic       valid_out,
    output logic       active
);

    typedef enum logic [1:0] {
        SEARCH    = 2'd0,
        ALIGN     = 2'd1,
        ACTIVE_ST = 2'd2
    } state_t;

    localparam logic [3:0] COM_CNT_MAX = 4'(COM_COUNT);

    state_t     state_q, state_d;
    logic [7:0] sr_q;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] com_cnt_q, com_cnt_d;
    logic [7:0] data_out_q, data_out_d;
    logic       byte_stb_q, byte_stb_d;
    logic       valid_q, valid_d;
    logic       active_q, active_d;
    logic       is_com;
    logic       boundary;

    // The shifter runs through reset; its contents are re-qualified by the search anyway.
    always_ff @(posedge clk_32f) begin
        sr_q <= {sr_q[6:0], data_in};
    end

    assign is_com   = (sr_q == COM);
    assign boundary = (bit_cnt_q == 3'd0);

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state_q    <= SEARCH;
            bit_cnt_q  <= 3'd0;
            com_cnt_q  <= 4'd0;
            data_out_q <= 8'h00;
            byte_stb_q <= 1'b0;
            valid_q    <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            com_cnt_q  <= com_cnt_d;
            data_out_q <= data_out_d;
            byte_stb_q <= byte_stb_d;
            valid_q    <= valid_d;
            active_q   <= active_d;
        end
    end

    // Anchoring loads 1 so the counter wraps to 0 exactly 8 clocks after the detecting cycle.
    always_comb begin
        state_d   = state_q;
        com_cnt_d = com_cnt_q;
        bit_cnt_d = bit_cnt_q + 3'd1;
        case (state_q)
            SEARCH: begin
                if (is_com) begin
                    bit_cnt_d = 3'd1;
                    com_cnt_d = 4'd1;
                    state_d   = (COM_CNT_MAX <= 4'd1) ? ACTIVE_ST : ALIGN;
                end
            end
            ALIGN: begin
                if (boundary) begin
                    if (!is_com) begin
                        state_d   = SEARCH;
                        com_cnt_d = 4'd0;
                    end else if (com_cnt_q >= COM_CNT_MAX - 4'd1) begin
                        com_cnt_d = COM_CNT_MAX;
                        state_d   = ACTIVE_ST;
                    end else begin
                        com_cnt_d = com_cnt_q + 4'd1;
                    end
                end
            end
            ACTIVE_ST: begin
                state_d = ACTIVE_ST;
            end
            default: begin
                state_d   = SEARCH;
                com_cnt_d = 4'd0;
            end
        endcase
    end

    always_comb begin
        data_out_d = data_out_q;
        valid_d    = valid_q;
        byte_stb_d = 1'b0;
        active_d   = (state_d == ACTIVE_ST);
        if (state_q == ACTIVE_ST && boundary) begin
            data_out_d = sr_q;
            byte_stb_d = 1'b1;
            valid_d    = !is_com;
        end
    end

    assign data_out  = data_out_q;
    assign byte_stb  = byte_stb_q;
    assign valid_out = valid_q;
    assign active    = active_q;

endmodule

// File: tb/tb_serial_paralelo.sv
// tb/tb_serial_paralelo.sv - directed table-driven bench for serial_paralelo
// Bytes are shifted MSB first; each record is checked one clock after its LSB edge.
module tb_serial_paralelo;

    logic       clk_32f = 1'b0;
    logic       reset   = 1'b1;
    logic       data_in = 1'b0;
    logic [7:0] data_out, data_out1;
    logic       byte_stb, valid_out, active;
    logic       byte_stb1, valid_out1, active1;

    always #5 clk_32f = ~clk_32f;

    serial_paralelo #(.COM(8'hBC), .COM_COUNT(4)) dut (
        .clk_32f(clk_32f), .reset(reset), .data_in(data_in),
        .data_out(data_out), .byte_stb(byte_stb), .valid_out(valid_out), .active(active)
    );

    serial_paralelo #(.COM(8'hBC), .COM_COUNT(1)) dut1 (
        .clk_32f(clk_32f), .reset(reset), .data_in(data_in),
        .data_out(data_out1), .byte_stb(byte_stb1), .valid_out(valid_out1), .active(active1)
    );

    typedef struct {
        logic [7:0] tx;
        logic       stb;
        logic [7:0] dout;
        logic       vld;
        logic       act;
    } vec_t;

    vec_t vec[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [7:0] act_v, input logic [7:0] exp_v);
        n_cmp++;
        if (act_v !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act_v, exp_v);
        end
    endtask

    task automatic step(input logic b);
        data_in = b;
        @(posedge clk_32f);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (8) step(1'b0);
        reset = 1'b0;
    endtask

    task automatic add(input logic [7:0] tx, input logic stb, input logic [7:0] dout,
                       input logic vld, input logic act);
        vec_t r;
        r.tx = tx; r.stb = stb; r.dout = dout; r.vld = vld; r.act = act;
        vec.push_back(r);
    endtask

    task automatic check_rec(input vec_t r, input int idx);
        check($sformatf("v%0d_tx%h byte_stb", idx, r.tx), 8'(byte_stb), 8'(r.stb));
        check($sformatf("v%0d_tx%h data_out", idx, r.tx), data_out, r.dout);
        check($sformatf("v%0d_tx%h valid_out", idx, r.tx), 8'(valid_out), 8'(r.vld));
        check($sformatf("v%0d_tx%h active", idx, r.tx), 8'(active), 8'(r.act));
    endtask

    task automatic run_vectors();
        vec_t prev;
        bit   have_prev;
        have_prev = 1'b0;
        foreach (vec[k]) begin
            for (int i = 7; i >= 0; i--) begin
                step(vec[k].tx[i]);
                if (i == 7 && have_prev) check_rec(prev, k - 1);
                else check("stb_between_bytes", 8'(byte_stb), 8'h00);
            end
            prev      = vec[k];
            have_prev = 1'b1;
        end
        if (have_prev) begin
            step(1'b0);
            check_rec(prev, vec.size() - 1);
        end
        vec.delete();
    endtask

    task automatic add_acquire();
        add(8'hBC, 1'b0, 8'h00, 1'b0, 1'b0);
        add(8'hBC, 1'b0, 8'h00, 1'b0, 1'b0);
        add(8'hBC, 1'b0, 8'h00, 1'b0, 1'b0);
        add(8'hBC, 1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    initial begin
        logic       any_stb;
        logic [7:0] b;

        // Reset with random line data, then a silent all-zero line
        reset = 1'b1;
        repeat (3) step(1'($urandom_range(1, 0)));
        check("rst data_out", data_out, 8'h00);
        check("rst valid_out", 8'(valid_out), 8'h00);
        check("rst byte_stb", 8'(byte_stb), 8'h00);
        check("rst active", 8'(active), 8'h00);
        reset   = 1'b0;
        any_stb = 1'b0;
        repeat (50) begin
            step(1'b0);
            if (byte_stb || active) any_stb = 1'b1;
        end
        check("zero_stream no stb/active", 8'(any_stb), 8'h00);

        // Acquisition and first data bytes
        do_reset();
        add_acquire();
        add(8'h01, 1'b1, 8'h01, 1'b1, 1'b1);
        add(8'h02, 1'b1, 8'h02, 1'b1, 1'b1);
        run_vectors();

        // Idle COM bytes while active
        do_reset();
        add_acquire();
        add(8'hA5, 1'b1, 8'hA5, 1'b1, 1'b1);
        add(8'hBC, 1'b1, 8'hBC, 1'b0, 1'b1);
        add(8'h5A, 1'b1, 8'h5A, 1'b1, 1'b1);
        run_vectors();

        // Misaligned start, broken COM run, then a clean acquisition
        do_reset();
        repeat (3) begin
            step(1'b0);
            check("junk stb", 8'(byte_stb), 8'h00);
        end
        add(8'hBC, 1'b0, 8'h00, 1'b0, 1'b0);
        add(8'hBC, 1'b0, 8'h00, 1'b0, 1'b0);
        add(8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        add_acquire();
        add(8'h77, 1'b1, 8'h77, 1'b1, 1'b1);
        run_vectors();

        // Reset coinciding with a boundary, then reacquisition required
        do_reset();
        add_acquire();
        add(8'h11, 1'b1, 8'h11, 1'b1, 1'b1);
        run_vectors();
        b = 8'h7E;
        for (int i = 6; i >= 0; i--) begin
            step(b[i]);
            check("pre_reset stb", 8'(byte_stb), 8'h00);
        end
        reset = 1'b1;
        step(1'b0);
        check("midrst byte_stb", 8'(byte_stb), 8'h00);
        check("midrst data_out", data_out, 8'h00);
        check("midrst valid_out", 8'(valid_out), 8'h00);
        check("midrst active", 8'(active), 8'h00);
        reset = 1'b0;
        add(8'h22, 1'b0, 8'h00, 1'b0, 1'b0);
        add(8'h33, 1'b0, 8'h00, 1'b0, 1'b0);
        add(8'h44, 1'b0, 8'h00, 1'b0, 1'b0);
        add(8'h55, 1'b0, 8'h00, 1'b0, 1'b0);
        add_acquire();
        add(8'h66, 1'b1, 8'h66, 1'b1, 1'b1);
        run_vectors();

        // COM_COUNT = 1 instance: one COM then C3
        do_reset();
        b = 8'hBC;
        for (int i = 7; i >= 0; i--) step(b[i]);
        check("cc1 active before", 8'(active1), 8'h00);
        b = 8'hC3;
        step(b[7]);
        check("cc1 active", 8'(active1), 8'h01);
        check("cc1 no early stb", 8'(byte_stb1), 8'h00);
        for (int i = 6; i >= 0; i--) begin
            step(b[i]);
            check("cc1 stb idle", 8'(byte_stb1), 8'h00);
        end
        step(1'b0);
        check("cc1 byte_stb", 8'(byte_stb1), 8'h01);
        check("cc1 data_out", data_out1, 8'hC3);
        check("cc1 valid_out", 8'(valid_out1), 8'h01);
        step(1'b0);
        check("cc1 stb one cycle", 8'(byte_stb1), 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
